loopback_buffer: RTL

- Parametrised byte loopback buffer between the USB device OUT stream and the IN stream.
- Replaces the direct out→in wire of the current loopback design with a FIFO of configurable width and depth.
- Adds runtime transform/release modes: stream, invert, and line-buffered.
- Sits in the application clock domain next to the DFU application block and exposes occupancy and traffic status for LED and debug use.

---
 rtl/loopback_pkg.sv | 13 +
 rtl/loopback_ram.sv | 19 +
 rtl/loopback_buffer.sv | 104 ++++++++++
 3 files changed

// File: rtl/loopback_pkg.sv
// loopback_pkg: shared mode/state encodings and default line terminator for loopback_buffer
package loopback_pkg;
  typedef enum logic [1:0] {
    MODE_STREAM = 2'd0,
    MODE_INVERT = 2'd1,
    MODE_LINE   = 2'd2
  } mode_e;
  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } line_state_e;
  localparam logic [7:0] DEFAULT_TERM = 8'h0A;
endpackage

// File: rtl/loopback_ram.sv
// loopback_ram: simple dual-port DEPTH x DATA_W memory with registered read port (EBR-friendly, no reset)
module loopback_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/loopback_buffer.sv
// loopback_buffer: valid/ready byte loopback FIFO with STREAM/INVERT/LINE release modes; define LOOPBACK_STATS_EN for traffic counters and sticky overflow
module loopback_buffer
  import loopback_pkg::*;
#(
  parameter int         DATA_W = 8,
  parameter int         DEPTH  = 64,
  parameter logic [7:0] TERM   = DEFAULT_TERM,
  parameter int         CNT_W  = 16
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [1:0]             mode_i,
  input  logic                   flush_i,
  input  logic [DATA_W-1:0]      rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  output logic [DATA_W-1:0]      tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  output logic [CNT_W-1:0]       rx_count_o,
  output logic [CNT_W-1:0]       tx_count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [AW:0] wr_ptr, rd_ptr, level, avail, pending, commit_q;
  logic [AW:0] wr_ptr_d, rd_ptr_d, avail_d, pending_d, commit_d;
  logic [1:0] mode_q, mode_d;
  line_state_e state_q, state_d;
  logic init_q, full, wr, rd, term, line, close;
  logic [DATA_W-1:0] ram_q, wdata;
  assign level = wr_ptr - rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rx_ready_o = init_q && !full && !flush_i;
  assign tx_valid_o = state_q == ST_DRAIN;
  assign tx_data_o = tx_valid_o ? ram_q : '0;
  assign level_o = level;
  assign wr = rx_valid_i && rx_ready_o;
  assign rd = tx_valid_o && tx_ready_i;
  assign term = rx_data_i[7:0] == TERM;
  assign wdata = mode_q == MODE_INVERT ? ~rx_data_i : rx_data_i;
  loopback_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i(clk_i),
    .we(wr),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(wdata),
    .raddr(rd_ptr_d[AW-1:0]),
    .rdata(ram_q)
  );
  always_comb begin
    line = mode_q == MODE_LINE;
    close = wr && line && (term || (level == LW'(DEPTH - 1) && !rd));
    wr_ptr_d = flush_i ? '0 : wr_ptr + LW'(wr);
    rd_ptr_d = flush_i ? '0 : rd_ptr + LW'(rd);
    commit_d = flush_i || !wr ? '0 : !line ? LW'(1) : close ? pending + LW'(1) : '0;
    pending_d = flush_i ? '0 : (wr && line) ? (close ? '0 : pending + LW'(1)) : pending;
    avail_d = flush_i ? '0 : avail - LW'(rd) + commit_q;
    state_d = avail_d != '0 ? ST_DRAIN : ST_FILL;
    mode_d = (level == '0 && !wr && !rd) ? mode_i : mode_q;
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) state_q <= ST_FILL;
    else state_q <= state_d;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      avail    <= '0;
      pending  <= '0;
      commit_q <= '0;
      mode_q   <= MODE_STREAM;
      init_q   <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_d;
      rd_ptr   <= rd_ptr_d;
      avail    <= avail_d;
      pending  <= pending_d;
      commit_q <= commit_d;
      mode_q   <= mode_d;
      init_q   <= 1'b1;
    end
`ifdef LOOPBACK_STATS_EN
  logic [CNT_W-1:0] rx_cnt, tx_cnt;
  logic ovf;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      rx_cnt <= '0;
      tx_cnt <= '0;
      ovf    <= 1'b0;
    end else begin
      rx_cnt <= rx_cnt + CNT_W'(wr);
      tx_cnt <= tx_cnt + CNT_W'(rd);
      ovf    <= ovf | (rx_valid_i & full);
    end
  assign rx_count_o = rx_cnt;
  assign tx_count_o = tx_cnt;
  assign overflow_o = ovf;
`else
  assign rx_count_o = '0;
  assign tx_count_o = '0;
  assign overflow_o = 1'b0;
`endif
endmodule
